// File: rtl/div_seq_32_if.sv
// Operand/result handshake bundle between the pipeline control and the
// sequential divider.
interface div_seq_32_if #(
  parameter int width = 32
);
  logic             start;
  logic             sign;
  logic [width-1:0] A;
  logic [width-1:0] B;
  logic [width-1:0] Quot;
  logic [width-1:0] Rem;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, sign, A, B,
    input  Quot, Rem, busy, done, div_zero
  );

  modport slave (
    input  start, sign, A, B,
    output Quot, Rem, busy, done, div_zero
  );
endinterface

// File: rtl/div_seq_32.sv
// Restoring shift/subtract divider for DIV/DIVU: one iteration per clock,
// magnitudes in, sign correction in a final FIX cycle.
module div_seq_32 #(
  parameter int width = 32
) (
  input  logic        clk,
  input  logic        reset,
  div_seq_32_if.slave div
);
  localparam int CW = $clog2(width);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [width-1:0] prem_q, prem_d;   // partial remainder
  logic [width-1:0] dvd_q, dvd_d;     // dividend shifting out, quotient shifting in
  logic [width-1:0] dvs_q, dvs_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dzp_q, dzp_d;     // divide-by-zero result due on next edge
  logic [width-1:0] quot_q, quot_d;
  logic [width-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;

  logic [width:0]   shifted;
  logic [width:0]   trial;
  logic             borrow;

  // The remainder before a subtract is always below the divisor, so a
  // width+1-bit difference goes negative exactly when bit [width] is set.
  assign shifted = {prem_q, dvd_q[width-1]};
  assign trial   = shifted - {1'b0, dvs_q};
  assign borrow  = trial[width];

  always_comb begin
    // NOTE: every next-state value starts from its register so no path through the case leaves a signal unassigned and infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    prem_d     = prem_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    dzp_d      = dzp_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;

    case (state_q)
      IDLE: begin
        if (dzp_q) begin
          quot_d     = '1;
          rem_d      = dvd_q;
          div_zero_d = 1'b1;
          done_d     = 1'b1;
          dzp_d      = 1'b0;
        end else if (div.start) begin
          if (div.B == '0) begin
            dzp_d = 1'b1;
            dvd_d = div.A;
          end else begin
            dvd_d      = (div.sign && div.A[width-1]) ? -div.A : div.A;
            dvs_d      = (div.sign && div.B[width-1]) ? -div.B : div.B;
            qneg_d     = div.sign & (div.A[width-1] ^ div.B[width-1]);
            rneg_d     = div.sign & div.A[width-1];
            prem_d     = '0;
            cnt_d      = '0;
            div_zero_d = 1'b0;
            state_d    = RUN;
          end
        end
      end
      RUN: begin
        prem_d = borrow ? shifted[width-1:0] : trial[width-1:0];
        dvd_d  = {dvd_q[width-2:0], ~borrow};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(width - 1)) state_d = FIX;
      end
      FIX: begin
        quot_d  = qneg_q ? -dvd_q : dvd_q;
        rem_d   = rneg_q ? -prem_q : prem_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      prem_q     <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      dzp_q      <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prem_q     <= prem_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      dzp_q      <= dzp_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign div.Quot     = quot_q;
  assign div.Rem      = rem_q;
  assign div.busy     = (state_q != IDLE);
  assign div.done     = done_q;
  assign div.div_zero = div_zero_q;
endmodule

// File: tb/tb_div_seq_32.sv
// Directed bench for div_seq_32: latency, signed/unsigned results, divide by
// zero, ignored and back-to-back starts, and reset during an operation.
module tb_div_seq_32;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  div_seq_32_if #(.width(32)) dif ();

  div_seq_32 #(.width(32)) dut (
    .clk   (clk),
    .reset (reset),
    .div   (dif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  // Called at a negedge; the start is taken at the following posedge.
  task automatic pulse_start(input logic s, input logic [31:0] a, input logic [31:0] b);
    dif.start = 1'b1;
    dif.sign  = s;
    dif.A     = a;
    dif.B     = b;
    @(negedge clk);
    dif.start = 1'b0;
  endtask

  // Counts cycles after the accepting edge until done, sampling at negedges.
  task automatic wait_done(input int c0, output int lat, output int bc);
    lat = c0;
    bc  = 0;
    while (dif.done !== 1'b1 && lat < 100) begin
      if (dif.busy === 1'b1) bc++;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (dif.done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout got done=%b after %0d cycles req done=1", dif.done, lat);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks += 5;
    if (dif.Quot !== 32'h0)    begin errors++; $display("FAIL reset_quot got %h req 0", dif.Quot); end
    if (dif.Rem  !== 32'h0)    begin errors++; $display("FAIL reset_rem got %h req 0", dif.Rem); end
    if (dif.busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b req 0", dif.busy); end
    if (dif.done !== 1'b0)     begin errors++; $display("FAIL reset_done got %b req 0", dif.done); end
    if (dif.div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got %b req 0", dif.div_zero); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    int lat, bc;
    pulse_start(1'b0, 32'd100, 32'd7);
    wait_done(0, lat, bc);
    checks += 4;
    if (lat !== 33)          begin errors++; $display("FAIL u_latency got %0d req 33", lat); end
    if (bc !== 33)           begin errors++; $display("FAIL u_busy_cycles got %0d req 33", bc); end
    if (dif.Quot !== 32'd14) begin errors++; $display("FAIL u_quot got %h req %h", dif.Quot, 32'd14); end
    if (dif.Rem  !== 32'd2)  begin errors++; $display("FAIL u_rem got %h req %h", dif.Rem, 32'd2); end
    @(negedge clk);
    checks += 3;
    if (dif.done !== 1'b0)   begin errors++; $display("FAIL u_done_width got %b req 0", dif.done); end
    if (dif.busy !== 1'b0)   begin errors++; $display("FAIL u_busy_after got %b req 0", dif.busy); end
    if (dif.Quot !== 32'd14) begin errors++; $display("FAIL u_quot_hold got %h req %h", dif.Quot, 32'd14); end
  endtask

  task automatic test_signed();
    vec_t v[5];
    int lat, bc;
    v[0] = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF};
    v[1] = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1};
    v[2] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0};
    v[3] = '{1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0};
    v[4] = '{1'b0, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 32'd1};
    for (int i = 0; i < 5; i++) begin
      pulse_start(v[i].s, v[i].a, v[i].b);
      wait_done(0, lat, bc);
      checks += 3;
      if (lat !== 33)           begin errors++; $display("FAIL s%0d_latency got %0d req 33", i, lat); end
      if (dif.Quot !== v[i].q)  begin errors++; $display("FAIL s%0d_quot got %h req %h", i, dif.Quot, v[i].q); end
      if (dif.Rem  !== v[i].r)  begin errors++; $display("FAIL s%0d_rem got %h req %h", i, dif.Rem, v[i].r); end
      @(negedge clk);
    end
  endtask

  task automatic test_div_zero();
    int lat, bc;
    pulse_start(1'b0, 32'h1234, 32'h0);
    wait_done(0, lat, bc);
    checks += 5;
    if (lat !== 1)               begin errors++; $display("FAIL dz_latency got %0d req 1", lat); end
    if (bc !== 0)                begin errors++; $display("FAIL dz_busy got %0d req 0", bc); end
    if (dif.Quot !== 32'hFFFFFFFF) begin errors++; $display("FAIL dz_quot got %h req ffffffff", dif.Quot); end
    if (dif.Rem  !== 32'h1234)   begin errors++; $display("FAIL dz_rem got %h req 00001234", dif.Rem); end
    if (dif.div_zero !== 1'b1)   begin errors++; $display("FAIL dz_flag got %b req 1", dif.div_zero); end
    @(negedge clk);
    checks += 2;
    if (dif.done !== 1'b0)       begin errors++; $display("FAIL dz_done_width got %b req 0", dif.done); end
    if (dif.div_zero !== 1'b1)   begin errors++; $display("FAIL dz_flag_hold got %b req 1", dif.div_zero); end
    // Signed divide by zero returns the raw dividend, not its magnitude.
    pulse_start(1'b1, 32'hFFFFFFFB, 32'h0);
    wait_done(0, lat, bc);
    checks += 1;
    if (dif.Rem !== 32'hFFFFFFFB) begin errors++; $display("FAIL dz_signed_rem got %h req fffffffb", dif.Rem); end
    @(negedge clk);
    pulse_start(1'b0, 32'd9, 32'd3);
    checks += 2;
    if (dif.div_zero !== 1'b0)   begin errors++; $display("FAIL dz_clear got %b req 0", dif.div_zero); end
    if (dif.busy !== 1'b1)       begin errors++; $display("FAIL dz_next_busy got %b req 1", dif.busy); end
    wait_done(0, lat, bc);
    checks += 2;
    if (dif.Quot !== 32'd3)      begin errors++; $display("FAIL dz_next_quot got %h req 3", dif.Quot); end
    if (dif.Rem  !== 32'd0)      begin errors++; $display("FAIL dz_next_rem got %h req 0", dif.Rem); end
    @(negedge clk);
  endtask

  task automatic test_ignored_start();
    int lat, bc;
    pulse_start(1'b0, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    pulse_start(1'b1, 32'hFFFFFFCE, 32'd5);
    wait_done(10, lat, bc);
    checks += 3;
    if (lat !== 33)          begin errors++; $display("FAIL ign_latency got %0d req 33", lat); end
    if (dif.Quot !== 32'd14) begin errors++; $display("FAIL ign_quot got %h req %h", dif.Quot, 32'd14); end
    if (dif.Rem  !== 32'd2)  begin errors++; $display("FAIL ign_rem got %h req %h", dif.Rem, 32'd2); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    pulse_start(1'b0, 32'd100, 32'd7);
    wait_done(0, lat, bc);
    checks += 1;
    if (dif.Quot !== 32'd14) begin errors++; $display("FAIL b2b_first_quot got %h req %h", dif.Quot, 32'd14); end
    pulse_start(1'b0, 32'd50, 32'd8);
    wait_done(0, lat, bc);
    checks += 3;
    if (lat !== 33)          begin errors++; $display("FAIL b2b_latency got %0d req 33", lat); end
    if (dif.Quot !== 32'd6)  begin errors++; $display("FAIL b2b_quot got %h req 6", dif.Quot); end
    if (dif.Rem  !== 32'd2)  begin errors++; $display("FAIL b2b_rem got %h req 2", dif.Rem); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    bit seen;
    pulse_start(1'b0, 32'd100, 32'd7);
    repeat (16) @(negedge clk);
    reset = 1'b1;
    #1;
    checks += 4;
    if (dif.Quot !== 32'h0)  begin errors++; $display("FAIL rst_mid_quot got %h req 0", dif.Quot); end
    if (dif.Rem  !== 32'h0)  begin errors++; $display("FAIL rst_mid_rem got %h req 0", dif.Rem); end
    if (dif.busy !== 1'b0)   begin errors++; $display("FAIL rst_mid_busy got %b req 0", dif.busy); end
    if (dif.done !== 1'b0)   begin errors++; $display("FAIL rst_mid_done got %b req 0", dif.done); end
    @(negedge clk);
    reset = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dif.done === 1'b1 || dif.busy === 1'b1) seen = 1'b1;
    end
    checks += 1;
    if (seen !== 1'b0)       begin errors++; $display("FAIL rst_mid_no_done got %b req 0", seen); end
    pulse_start(1'b0, 32'd9, 32'd3);
    wait_done(0, lat, bc);
    checks += 3;
    if (lat !== 33)          begin errors++; $display("FAIL rst_fresh_latency got %0d req 33", lat); end
    if (dif.Quot !== 32'd3)  begin errors++; $display("FAIL rst_fresh_quot got %h req 3", dif.Quot); end
    if (dif.Rem  !== 32'd0)  begin errors++; $display("FAIL rst_fresh_rem got %h req 0", dif.Rem); end
    @(negedge clk);
  endtask

  initial begin
    dif.start = 1'b0;
    dif.sign  = 1'b0;
    dif.A     = '0;
    dif.B     = '0;
    reset     = 1'b1;
    @(negedge clk);
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
